// File: rtl/nd_2to1_arb_if.sv
// nd_2to1_arb_if: two-phase req/ack message link.
// master drives req/dat and receives ack; slave receives req/dat and drives ack.
// A message is pending while req != ack; dat is valid while pending.
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
interface nd_2to1_arb_if #(parameter int DSZ = `NS_DATA_SIZE);
    logic           req;
    logic [DSZ-1:0] dat;
    logic           ack;
    modport master (output req, output dat, input ack);
    modport slave  (input req, input dat, output ack);
endinterface

// File: rtl/nd_2to1_arb.sv
// nd_2to1_arb: merges two two-phase links (rcv0, rcv1) onto one (snd0), one registered message in flight.
// Ports: i_clk, i_rst_n (async active-low); rcv0/rcv1 slave links; snd0 master link;
//        o_busy (message in flight), o_last_grant (last granted input), o_cnt0/o_cnt1 (forwarded counts, wrapping).
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
module nd_2to1_arb #(
    parameter int DSZ       = `NS_DATA_SIZE,
    parameter int PRIO_MODE = 0,
    parameter int CNT_SZ    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    nd_2to1_arb_if.slave      rcv0,
    nd_2to1_arb_if.slave      rcv1,
    nd_2to1_arb_if.master     snd0,
    output logic              o_busy,
    output logic              o_last_grant,
    output logic [CNT_SZ-1:0] o_cnt0,
    output logic [CNT_SZ-1:0] o_cnt1
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t             state_q, state_d;
    logic               ack0_q, ack0_d, ack1_q, ack1_d, req_q, req_d, last_q, last_d;
    logic [DSZ-1:0]     dat_q, dat_d;
    logic [CNT_SZ-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic               pend0, pend1, out_pend, grant, pick1;
    assign pend0    = rcv0.req != ack0_q;
    assign pend1    = rcv1.req != ack1_q;
    assign out_pend = req_q != snd0.ack;
    // A new grant may happen from IDLE, or in WAIT on the very edge the sink acks.
    assign grant    = (state_q == S_IDLE || !out_pend) && (pend0 || pend1);
    // rcv1 wins when alone, or in a round-robin tie when rcv0 was served last.
    assign pick1    = pend1 && (!pend0 || (PRIO_MODE == 0 && !last_q));
    always_comb begin
        state_d = state_q;
        ack0_d  = ack0_q;
        ack1_d  = ack1_q;
        req_d   = req_q;
        dat_d   = dat_q;
        last_d  = last_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        if (grant) begin
            dat_d   = pick1 ? rcv1.dat : rcv0.dat;
            ack0_d  = ack0_q ^ !pick1;
            ack1_d  = ack1_q ^ pick1;
            req_d   = !req_q;
            last_d  = pick1;
            cnt0_d  = pick1 ? cnt0_q : cnt0_q + 1'b1;
            cnt1_d  = pick1 ? cnt1_q + 1'b1 : cnt1_q;
            state_d = S_WAIT;
        end else if (state_q == S_WAIT && !out_pend) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            req_q   <= 1'b0;
            dat_q   <= '0;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            req_q   <= req_d;
            dat_q   <= dat_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end
    assign rcv0.ack     = ack0_q;
    assign rcv1.ack     = ack1_q;
    assign snd0.req     = req_q;
    assign snd0.dat     = dat_q;
    assign o_busy       = state_q == S_WAIT;
    assign o_last_grant = last_q;
    assign o_cnt0       = cnt0_q;
    assign o_cnt1       = cnt1_q;
endmodule
